tpu_c_readback: RTL and testbench

Result-drain engine for the TPU: after the compute FSM has written output rows into the C global buffer, this block reads a contiguous range of C rows (DATAC_BITS wide) and serializes each row into DATA_BITS words on a valid/ready stream toward the host/CFU response path. It is the reading end of the C buffer write interface, and it shares the buffer's read port with nothing else while busy.

---
 rtl/tpu_pkg.sv | 19 +
 rtl/c_row_serializer.sv | 67 ++++++
 rtl/tpu_c_readback.sv | 119 +++++++++++
 tb/tb_tpu_c_readback.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions for the C-buffer readback path.
// Holds default widths, the derived words-per-row count and the
// readback FSM state encoding.
package tpu_pkg;

  localparam int DEF_ADDR_BITS  = 16;
  localparam int DEF_DATA_BITS  = 32;
  localparam int DEF_DATAC_BITS = 128;
  localparam int WORDS_PER_ROW  = DEF_DATAC_BITS / DEF_DATA_BITS;

  typedef enum logic [2:0] {
    RB_IDLE    = 3'd0,
    RB_ISSUE   = 3'd1,
    RB_CAPTURE = 3'd2,
    RB_SEND    = 3'd3,
    RB_FINISH  = 3'd4
  } rb_state_e;

endpackage

// File: rtl/c_row_serializer.sv
// Splits one C row into DATA_BITS words, most-significant word first,
// on a valid/ready stream.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          capture row_in and start presenting word 0
//   row_in        C row to serialize
//   out_ready     downstream accepts the presented word
//   out_valid     a word is being presented
//   out_data      presented word
//   last_beat     the presented word is the final word of the row
module c_row_serializer #(
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATAC_BITS-1:0] row_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_BITS-1:0]  out_data,
  output logic                  last_beat
);

  localparam int WORDS    = DATAC_BITS / DATA_BITS;
  localparam int CNT_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DATAC_BITS-1:0] row_q, row_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  // The row is shifted left on every accepted beat, so the presented word
  // is always the top slice; once drained the register is all zeros.
  assign out_valid = valid_q;
  assign out_data  = row_q[DATAC_BITS-1 -: DATA_BITS];
  assign last_beat = valid_q && (cnt_q == CNT_BITS'(WORDS - 1));

  always_comb begin
    row_d   = row_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      row_d   = row_in;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      row_d = row_q << DATA_BITS;
      cnt_d = cnt_q + CNT_BITS'(1);
      if (last_beat) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/tpu_c_readback.sv
// Result-drain engine: reads num_rows consecutive C buffer rows starting
// at base_index and streams each row out as DATA_BITS words, MSB word first.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle request, honoured only when idle
//   base_index, num_rows     drain range, latched on accepted start
//   busy                     drain in progress (through the done cycle)
//   done                     one-cycle completion pulse
//   C_rd_en, C_index         C buffer read port (data returns next cycle)
//   C_data_out               C buffer read data
//   out_valid/out_ready/out_data   serialized word stream
module tpu_c_readback
  import tpu_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int DATAC_BITS = DEF_DATAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_index,
  input  logic [ADDR_BITS-1:0]  num_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  C_rd_en,
  output logic [ADDR_BITS-1:0]  C_index,
  input  logic [DATAC_BITS-1:0] C_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BITS-1:0]  out_data
);

  rb_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS-1:0] num_q, num_d;
  logic [ADDR_BITS-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_BITS-1:0] row_inc;

  logic ser_load;
  logic ser_valid;
  logic ser_last;
  logic beat_fire;

  // Address wraps modulo 2^ADDR_BITS by construction of the adder width.
  assign C_index   = base_q + row_cnt_q;
  assign row_inc   = row_cnt_q + ADDR_BITS'(1);
  assign busy      = (state_q != RB_IDLE);
  assign out_valid = ser_valid;
  assign beat_fire = ser_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    row_cnt_d = row_cnt_q;
    C_rd_en   = 1'b0;
    done      = 1'b0;
    ser_load  = 1'b0;
    unique case (state_q)
      RB_IDLE: begin
        if (start) begin
          base_d    = base_index;
          num_d     = num_rows;
          row_cnt_d = '0;
          state_d   = (num_rows == '0) ? RB_FINISH : RB_ISSUE;
        end
      end
      RB_ISSUE: begin
        C_rd_en = 1'b1;
        state_d = RB_CAPTURE;
      end
      RB_CAPTURE: begin
        ser_load = 1'b1;
        state_d  = RB_SEND;
      end
      RB_SEND: begin
        if (beat_fire && ser_last) begin
          row_cnt_d = row_inc;
          state_d   = (row_inc == num_q) ? RB_FINISH : RB_ISSUE;
        end
      end
      RB_FINISH: begin
        done    = 1'b1;
        state_d = RB_IDLE;
      end
      default: state_d = RB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RB_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  c_row_serializer #(
    .DATA_BITS (DATA_BITS),
    .DATAC_BITS(DATAC_BITS)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .row_in   (C_data_out),
    .out_ready(out_ready),
    .out_valid(ser_valid),
    .out_data (out_data),
    .last_beat(ser_last)
  );

endmodule

// File: tb/tb_tpu_c_readback.sv
module tb_tpu_c_readback;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  base_index;
  logic [15:0]  num_rows;
  logic         busy;
  logic         done;
  logic         C_rd_en;
  logic [15:0]  C_index;
  logic [127:0] C_data_out = '0;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned edge_n = 0;

  tpu_c_readback #(
    .ADDR_BITS (16),
    .DATA_BITS (32),
    .DATAC_BITS(128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_index(base_index),
    .num_rows  (num_rows),
    .busy      (busy),
    .done      (done),
    .C_rd_en   (C_rd_en),
    .C_index   (C_index),
    .C_data_out(C_data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // C buffer content: row 5 holds 4,3,2,1; any other row a holds {a, 4-w}.
  function automatic logic [31:0] gen_word(input logic [15:0] a, input int w);
    logic [15:0] lo;
    lo = 16'(4 - w);
    if (a == 16'd5) return {16'd0, lo};
    return {a, lo};
  endfunction

  function automatic logic [127:0] mk_row(input logic [15:0] a);
    return {gen_word(a, 0), gen_word(a, 1), gen_word(a, 2), gen_word(a, 3)};
  endfunction

  always @(posedge clk) if (C_rd_en) C_data_out <= mk_row(C_index);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] num;
    int          mode;       // 0: ready always high, 1: ready 1,0,0 repeating
    bit          inject;     // second start during SEND
    int          exp_words;
    int          exp_reads;
    int          exp_done;
    int          exp_fv;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  int          r_words, r_reads, r_done_at, r_ndone, r_fv;
  logic [31:0] r_first, r_last;
  int unsigned t0;

  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    base_index = b;
    num_rows = n;
    @(posedge clk);
    #1;
    t0 = edge_n;
    start = 1'b0;
    base_index = 16'h1234;
    num_rows = 16'h0007;
  endtask

  task automatic run_drain(input vec_t v);
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [15:0] exp_idx;
    bit          injected;
    int          cyc;
    r_words = 0; r_reads = 0; r_done_at = -1; r_ndone = 0; r_fv = -1;
    r_first = '0; r_last = '0;
    prev_stall = 1'b0; prev_data = '0; injected = 1'b0;
    do_start(v.base, v.num);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc = int'(edge_n - t0) + 1;
      out_ready = (v.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      start = 1'b0;
      if (v.inject && !injected && out_valid) begin
        start = 1'b1;
        base_index = 16'h0100;
        num_rows = 16'd1;
        injected = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (C_rd_en) begin
        exp_idx = v.base + 16'(r_reads);
        check("rd_index", 64'(C_index), 64'(exp_idx));
        r_reads++;
      end
      if (out_valid && r_fv < 0) r_fv = cyc;
      if (out_valid && out_ready) begin
        check("word", 64'(out_data), 64'(gen_word(v.base + 16'(r_words / 4), r_words % 4)));
        if (r_words == 0) r_first = out_data;
        r_last = out_data;
        r_words++;
      end
      if (done) begin
        r_ndone++;
        if (r_ndone == 1) r_done_at = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (r_ndone > 0 && cyc >= r_done_at + 3) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("words", 64'(r_words), 64'(v.exp_words));
    check("reads", 64'(r_reads), 64'(v.exp_reads));
    check("done_at", 64'(r_done_at), 64'(v.exp_done));
    check("done_count", 64'(r_ndone), 64'd1);
    check("first_valid_at", 64'(r_fv), 64'(v.exp_fv));
    check("first_word", 64'(r_first), 64'(v.exp_first));
    check("last_word", 64'(r_last), 64'(v.exp_last));
    check("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int nw;
    vecs[0] = '{16'h0005, 16'd1, 0, 1'b0, 4,  1, 7,  3,  32'h0000_0004, 32'h0000_0001};
    vecs[1] = '{16'h0005, 16'd1, 1, 1'b0, 4,  1, 13, 3,  32'h0000_0004, 32'h0000_0001};
    vecs[2] = '{16'hFFFE, 16'd3, 0, 1'b0, 12, 3, 19, 3,  32'hFFFE_0004, 32'h0000_0001};
    vecs[3] = '{16'h0000, 16'd0, 0, 1'b0, 0,  0, 1,  -1, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{16'h0040, 16'd4, 0, 1'b1, 16, 4, 25, 3,  32'h0040_0004, 32'h0043_0001};
    vecs[5] = '{16'h000A, 16'd2, 1, 1'b0, 8,  2, 25, 3,  32'h000A_0004, 32'h000B_0001};

    rst = 1'b1; start = 1'b0; base_index = '0; num_rows = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_en", 64'(C_rd_en), 64'd0);
    check("rst_index", 64'(C_index), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_drain(vecs[i]);

    // Reset after word 1 of row 2 of a 4-row drain (that beat transfers at end of cycle 16).
    nw = 0;
    do_start(16'h0020, 16'd4);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      cyc = int'(edge_n - t0) + 1;
      if (cyc == 17) break;
      #1;
      if (out_valid && out_ready) nw++;
    end
    check("pre_reset_words", 64'(nw), 64'd10);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_rd_en", 64'(C_rd_en), 64'd0);
    check("mid_rst_index", 64'(C_index), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    check("rst_hold_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_done", 64'(done), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    run_drain(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
